// File: rtl/cpu_core_debug_pkg.sv
// Shared types and register map for the core debug controller.
// Holds the FSM encoding, word offsets, CTRL/STATUS bit positions and a byte-strobe merge helper.
package cpu_core_debug_pkg;

   typedef enum logic [1:0] {
      ST_HALT = 2'd0,
      ST_RUN  = 2'd1,
      ST_STEP = 2'd2
   } dbg_state_e;

   localparam logic [31:0] OFF_CTRL       = 32'h000;
   localparam logic [31:0] OFF_STATUS     = 32'h004;
   localparam logic [31:0] OFF_STEP_COUNT = 32'h008;
   localparam logic [31:0] OFF_CYCLE      = 32'h00C;
   localparam logic [31:0] OFF_BP_EN      = 32'h010;
   localparam logic [31:0] OFF_BP_ADDR    = 32'h040;
   localparam logic [31:0] OFF_REG        = 32'h100;
   localparam logic [31:0] OFF_PC         = 32'h180;

   localparam int CTRL_RUN       = 0;
   localparam int CTRL_STOP      = 1;
   localparam int CTRL_STEP      = 2;
   localparam int CTRL_CLR_CYCLE = 3;

   localparam int STAT_STATE_LSB  = 0;
   localparam int STAT_BP_HIT     = 2;
   localparam int STAT_BP_IDX_LSB = 8;

   function automatic logic [31:0] merge_strb(input logic [31:0] cur,
                                              input logic [31:0] wd,
                                              input logic [3:0]  strb);
      logic [31:0] res;
      res = cur;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) res[8*b +: 8] = wd[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/cpu_core_debug_axil_if.sv
// AXI-Lite slave front end: turns channel handshakes into single-cycle wr_en / rd_en strobes.
// BVALID one cycle after AW and W are both held, RVALID one cycle after AR; one write and one read outstanding.
module cpu_core_debug_axil_if #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 16
) (
   input  logic                              s_axi_aclk,
   input  logic                              s_axi_aresetn,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
   input  logic                              s_axi_awvalid,
   output logic                              s_axi_awready,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_wdata,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
   input  logic                              s_axi_wvalid,
   output logic                              s_axi_wready,
   output logic [1:0]                        s_axi_bresp,
   output logic                              s_axi_bvalid,
   input  logic                              s_axi_bready,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_araddr,
   input  logic                              s_axi_arvalid,
   output logic                              s_axi_arready,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_rdata,
   output logic [1:0]                        s_axi_rresp,
   output logic                              s_axi_rvalid,
   input  logic                              s_axi_rready,
   output logic                              wr_en,
   output logic [C_S_AXI_ADDR_WIDTH-1:0]     wr_addr,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     wr_data,
   output logic [C_S_AXI_DATA_WIDTH/8-1:0]   wr_strb,
   output logic                              rd_en,
   output logic [C_S_AXI_ADDR_WIDTH-1:0]     rd_addr,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]     rd_data
);

   logic aw_held, w_held;

   // Ready terms are gated by reset so every ready reads 0 while reset is asserted.
   assign s_axi_awready = s_axi_aresetn & ~aw_held & ~s_axi_bvalid;
   assign s_axi_wready  = s_axi_aresetn & ~w_held  & ~s_axi_bvalid;
   assign s_axi_arready = s_axi_aresetn & ~s_axi_rvalid;
   assign s_axi_bresp   = 2'b00;
   assign s_axi_rresp   = 2'b00;

   assign wr_en   = aw_held & w_held;
   assign rd_en   = s_axi_arvalid & s_axi_arready;
   assign rd_addr = s_axi_araddr;

   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         aw_held      <= 1'b0;
         w_held       <= 1'b0;
         wr_addr      <= '0;
         wr_data      <= '0;
         wr_strb      <= '0;
         s_axi_bvalid <= 1'b0;
         s_axi_rvalid <= 1'b0;
         s_axi_rdata  <= '0;
      end else begin
         if (s_axi_awvalid && s_axi_awready) begin
            aw_held <= 1'b1;
            wr_addr <= s_axi_awaddr;
         end
         if (s_axi_wvalid && s_axi_wready) begin
            w_held  <= 1'b1;
            wr_data <= s_axi_wdata;
            wr_strb <= s_axi_wstrb;
         end
         if (wr_en) begin
            aw_held      <= 1'b0;
            w_held       <= 1'b0;
            s_axi_bvalid <= 1'b1;
         end else if (s_axi_bvalid && s_axi_bready) begin
            s_axi_bvalid <= 1'b0;
         end
         if (rd_en) begin
            s_axi_rvalid <= 1'b1;
            s_axi_rdata  <= rd_data;
         end else if (s_axi_rvalid && s_axi_rready) begin
            s_axi_rvalid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/cpu_core_debug_controller.sv
// Core run-control block: HALT/RUN/STEP gating of cexec, PC breakpoints, cycle counter, register snooping.
// cexec is combinational from state and breakpoint match; register access latency is set by the AXI-Lite front end.
module cpu_core_debug_controller
   import cpu_core_debug_pkg::*;
#(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 16,
   parameter int NUM_REGS           = 32,
   parameter int NUM_BP             = 2
) (
   input  logic                              s_axi_aclk,
   input  logic                              s_axi_aresetn,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
   input  logic [2:0]                        s_axi_awprot,
   input  logic                              s_axi_awvalid,
   output logic                              s_axi_awready,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_wdata,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
   input  logic                              s_axi_wvalid,
   output logic                              s_axi_wready,
   output logic [1:0]                        s_axi_bresp,
   output logic                              s_axi_bvalid,
   input  logic                              s_axi_bready,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_araddr,
   input  logic [2:0]                        s_axi_arprot,
   input  logic                              s_axi_arvalid,
   output logic                              s_axi_arready,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_rdata,
   output logic [1:0]                        s_axi_rresp,
   output logic                              s_axi_rvalid,
   input  logic                              s_axi_rready,
   output logic                              cexec,
   input  logic [NUM_REGS*32-1:0]            core_regs,
   input  logic [31:0]                       core_pc
);

   logic                            wr_en, rd_en;
   logic [C_S_AXI_ADDR_WIDTH-1:0]   wr_addr, rd_addr;
   logic [C_S_AXI_DATA_WIDTH-1:0]   wr_data, rd_data;
   logic [C_S_AXI_DATA_WIDTH/8-1:0] wr_strb;
   logic                            unused_prot;

   assign unused_prot = ^{s_axi_awprot, s_axi_arprot};

   cpu_core_debug_axil_if #(
      .C_S_AXI_DATA_WIDTH(C_S_AXI_DATA_WIDTH),
      .C_S_AXI_ADDR_WIDTH(C_S_AXI_ADDR_WIDTH)
   ) u_axil_if (
      .s_axi_aclk(s_axi_aclk),       .s_axi_aresetn(s_axi_aresetn),
      .s_axi_awaddr(s_axi_awaddr),   .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
      .s_axi_wdata(s_axi_wdata),     .s_axi_wstrb(s_axi_wstrb),
      .s_axi_wvalid(s_axi_wvalid),   .s_axi_wready(s_axi_wready),
      .s_axi_bresp(s_axi_bresp),     .s_axi_bvalid(s_axi_bvalid),   .s_axi_bready(s_axi_bready),
      .s_axi_araddr(s_axi_araddr),   .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
      .s_axi_rdata(s_axi_rdata),     .s_axi_rresp(s_axi_rresp),
      .s_axi_rvalid(s_axi_rvalid),   .s_axi_rready(s_axi_rready),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data)
   );

   dbg_state_e        state, state_nxt;
   logic [31:0]       step_count, remaining, cycle_cnt, status;
   logic [NUM_BP-1:0] bp_en;
   logic [31:0]       bp_addr [NUM_BP];
   logic              bp_hit, first_run, bp_any, bp_match;
   logic [2:0]        bp_idx, bp_idx_nxt;
   logic [31:0]       wr_off, rd_off;
   logic [4:0]        reg_k;
   logic              ctrl_wr, cmd_run, cmd_stop, cmd_step, cmd_clr;
   logic [31:0]       regs_arr [NUM_REGS];

   for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs
      assign regs_arr[k] = core_regs[32*k +: 32];
   end

   assign wr_off   = 32'(wr_addr) & ~32'h3;
   assign rd_off   = 32'(rd_addr) & ~32'h3;
   assign reg_k    = rd_off[6:2];
   assign ctrl_wr  = wr_en && (wr_off == OFF_CTRL) && wr_strb[0];
   assign cmd_run  = ctrl_wr & wr_data[CTRL_RUN];
   assign cmd_stop = ctrl_wr & wr_data[CTRL_STOP];
   assign cmd_step = ctrl_wr & wr_data[CTRL_STEP];
   assign cmd_clr  = ctrl_wr & wr_data[CTRL_CLR_CYCLE];

   // Descending scan so the lowest matching index is the one left in bp_idx_nxt.
   always_comb begin
      bp_any     = 1'b0;
      bp_idx_nxt = '0;
      for (int i = NUM_BP - 1; i >= 0; i--) begin
         if (bp_en[i] && (bp_addr[i] == core_pc)) begin
            bp_any     = 1'b1;
            bp_idx_nxt = 3'(i);
         end
      end
   end

   // first_run lets a resume step off the PC that caused the previous breakpoint halt.
   assign bp_match = bp_any && (state == ST_RUN) && !first_run;

   always_comb begin
      state_nxt = state;
      cexec     = 1'b0;
      case (state)
         ST_HALT: begin
            if (!cmd_stop && cmd_run)                              state_nxt = ST_RUN;
            else if (!cmd_stop && cmd_step && step_count != 32'd0) state_nxt = ST_STEP;
         end
         ST_RUN: begin
            cexec = !bp_match;
            if (cmd_stop || bp_match) state_nxt = ST_HALT;
         end
         ST_STEP: begin
            cexec = 1'b1;
            if (cmd_stop || remaining == 32'd1) state_nxt = ST_HALT;
         end
         default: state_nxt = ST_HALT;
      endcase
   end

   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         state      <= ST_HALT;
         first_run  <= 1'b0;
         remaining  <= '0;
         step_count <= '0;
         cycle_cnt  <= '0;
         bp_en      <= '0;
         bp_hit     <= 1'b0;
         bp_idx     <= '0;
         for (int i = 0; i < NUM_BP; i++) bp_addr[i] <= '0;
      end else begin
         state     <= state_nxt;
         first_run <= (state == ST_HALT) && (state_nxt == ST_RUN);
         if (state == ST_HALT && state_nxt == ST_STEP) remaining <= step_count;
         else if (state == ST_STEP)                    remaining <= remaining - 32'd1;
         if (bp_match) begin
            bp_hit <= 1'b1;
            bp_idx <= bp_idx_nxt;
         end else if (state == ST_HALT && state_nxt == ST_RUN) begin
            bp_hit <= 1'b0;
         end
         if (cmd_clr)    cycle_cnt <= '0;
         else if (cexec) cycle_cnt <= cycle_cnt + 32'd1;
         if (wr_en) begin
            if (wr_off == OFF_STEP_COUNT) step_count <= merge_strb(step_count, wr_data, wr_strb);
            if (wr_off == OFF_BP_EN)      bp_en <= NUM_BP'(merge_strb(32'(bp_en), wr_data, wr_strb));
            for (int i = 0; i < NUM_BP; i++) begin
               if (wr_off == OFF_BP_ADDR + 32'(4*i))
                  bp_addr[i] <= merge_strb(bp_addr[i], wr_data, wr_strb);
            end
         end
      end
   end

   always_comb begin
      status = '0;
      status[STAT_STATE_LSB +: 2]  = state;
      status[STAT_BP_HIT]          = bp_hit;
      status[STAT_BP_IDX_LSB +: 3] = bp_idx;
   end

   // Live inputs are muxed here and captured by the front end on the AR handshake.
   always_comb begin
      rd_data = '0;
      if (rd_en) begin
         case (rd_off)
            OFF_STATUS:     rd_data = status;
            OFF_STEP_COUNT: rd_data = step_count;
            OFF_CYCLE:      rd_data = cycle_cnt;
            OFF_BP_EN:      rd_data = 32'(bp_en);
            OFF_PC:         rd_data = core_pc;
            default: begin
               for (int i = 0; i < NUM_BP; i++) begin
                  if (rd_off == OFF_BP_ADDR + 32'(4*i)) rd_data = bp_addr[i];
               end
               if (rd_off >= OFF_REG && rd_off < OFF_REG + 32'h80 && int'(reg_k) < NUM_REGS)
                  rd_data = regs_arr[reg_k];
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_core_debug_controller.sv
// Directed bench for cpu_core_debug_controller: register map, stepping, breakpoints, cycle wrap and reset abort.
module tb_cpu_core_debug_controller;

   localparam int NR = 32;
   localparam int NB = 2;

   logic          s_axi_aclk = 1'b0;
   logic          s_axi_aresetn;
   logic [15:0]   s_axi_awaddr, s_axi_araddr;
   logic [2:0]    s_axi_awprot, s_axi_arprot;
   logic          s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
   logic [31:0]   s_axi_wdata, s_axi_rdata;
   logic [3:0]    s_axi_wstrb;
   logic [1:0]    s_axi_bresp, s_axi_rresp;
   logic          s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
   logic          s_axi_rvalid, s_axi_rready;
   logic          cexec;
   logic [NR*32-1:0] core_regs;
   logic [31:0]   core_pc;

   logic          ramp = 1'b0;
   logic [31:0]   pc_set = 32'h0;
   int            checks = 0;
   int            errors = 0;
   int            cexec_hi = 0;

   always #5 s_axi_aclk = ~s_axi_aclk;

   cpu_core_debug_controller #(
      .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(16), .NUM_REGS(NR), .NUM_BP(NB)
   ) dut (
      .s_axi_aclk(s_axi_aclk),       .s_axi_aresetn(s_axi_aresetn),
      .s_axi_awaddr(s_axi_awaddr),   .s_axi_awprot(s_axi_awprot),
      .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
      .s_axi_wdata(s_axi_wdata),     .s_axi_wstrb(s_axi_wstrb),
      .s_axi_wvalid(s_axi_wvalid),   .s_axi_wready(s_axi_wready),
      .s_axi_bresp(s_axi_bresp),     .s_axi_bvalid(s_axi_bvalid),   .s_axi_bready(s_axi_bready),
      .s_axi_araddr(s_axi_araddr),   .s_axi_arprot(s_axi_arprot),
      .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
      .s_axi_rdata(s_axi_rdata),     .s_axi_rresp(s_axi_rresp),
      .s_axi_rvalid(s_axi_rvalid),   .s_axi_rready(s_axi_rready),
      .cexec(cexec), .core_regs(core_regs), .core_pc(core_pc)
   );

   always @(negedge s_axi_aclk) if (cexec === 1'b1) cexec_hi <= cexec_hi + 1;

   // Core model: PC advances by 4 after every cycle in which cexec was high.
   initial begin
      logic ex;
      forever begin
         @(negedge s_axi_aclk);
         ex = cexec;
         @(posedge s_axi_aclk);
         #1;
         if (!ramp)   core_pc = pc_set;
         else if (ex) core_pc = core_pc + 32'd4;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge s_axi_aclk);
      #1;
   endtask

   task automatic axi_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
      int n;
      logic aw_go, w_go;
      s_axi_awaddr = a; s_axi_awvalid = 1'b1;
      s_axi_wdata = d;  s_axi_wstrb = s; s_axi_wvalid = 1'b1;
      s_axi_bready = 1'b1;
      n = 0;
      while ((s_axi_awvalid || s_axi_wvalid) && n < 20) begin
         @(negedge s_axi_aclk);
         aw_go = s_axi_awvalid & s_axi_awready;
         w_go  = s_axi_wvalid & s_axi_wready;
         @(posedge s_axi_aclk);
         #1;
         if (aw_go) s_axi_awvalid = 1'b0;
         if (w_go)  s_axi_wvalid = 1'b0;
         n++;
      end
      n = 0;
      while (n < 20) begin
         @(negedge s_axi_aclk);
         if (s_axi_bvalid) break;
         n++;
      end
      chk("bvalid_seen", {31'd0, s_axi_bvalid}, 32'd1);
      chk("bresp", {30'd0, s_axi_bresp}, 32'd0);
      @(posedge s_axi_aclk);
      #1;
      s_axi_bready = 1'b0; s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
   endtask

   task automatic axi_read(input logic [15:0] a, output logic [31:0] d, output logic [1:0] resp);
      int n;
      s_axi_araddr = a; s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
      n = 0;
      while (n < 20) begin
         @(negedge s_axi_aclk);
         if (s_axi_arready) break;
         n++;
      end
      @(posedge s_axi_aclk);
      #1;
      s_axi_arvalid = 1'b0;
      n = 0;
      while (n < 20) begin
         @(negedge s_axi_aclk);
         if (s_axi_rvalid) break;
         n++;
      end
      chk("rvalid_seen", {31'd0, s_axi_rvalid}, 32'd1);
      d = s_axi_rdata;
      resp = s_axi_rresp;
      @(posedge s_axi_aclk);
      #1;
      s_axi_rready = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input logic [15:0] a, input logic [31:0] mask,
                         input logic [31:0] exp);
      logic [31:0] d;
      logic [1:0]  r;
      axi_read(a, d, r);
      chk(tag, d & mask, exp);
   endtask

   initial begin
      logic [31:0] d;
      logic [1:0]  r;
      int base, n;
      s_axi_aresetn = 1'b0;
      s_axi_awaddr = '0; s_axi_awprot = '0; s_axi_awvalid = 1'b0;
      s_axi_wdata = '0;  s_axi_wstrb = '0;  s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
      s_axi_araddr = '0; s_axi_arprot = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
      for (int k = 0; k < NR; k++) core_regs[32*k +: 32] = 32'hA500_0000 + 32'(k);
      pc_set = 32'h1234_5678;

      #2;
      chk("rst_cexec", {31'd0, cexec}, 32'd0);
      chk("rst_readys", {29'd0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'd0);
      chk("rst_valids_rdata", {s_axi_rdata[29:0], s_axi_bvalid, s_axi_rvalid}, 32'd0);
      tick(3);
      s_axi_aresetn = 1'b1;
      tick(2);

      rd_chk("status_reset", 16'h004, 32'hFFFF_FFFF, 32'h0);
      rd_chk("cycle_reset", 16'h00C, 32'hFFFF_FFFF, 32'h0);
      rd_chk("reg5", 16'h114, 32'hFFFF_FFFF, 32'hA500_0005);
      rd_chk("reg31", 16'h17C, 32'hFFFF_FFFF, 32'hA500_001F);
      rd_chk("pc_live", 16'h180, 32'hFFFF_FFFF, 32'h1234_5678);
      axi_read(16'h200, d, r);
      chk("unmapped_rdata", d, 32'h0);
      chk("unmapped_rresp", {30'd0, r}, 32'h0);
      rd_chk("ctrl_write_only", 16'h000, 32'hFFFF_FFFF, 32'h0);

      axi_write(16'h00C, 32'hDEAD_BEEF, 4'hF);
      rd_chk("cycle_ro", 16'h00C, 32'hFFFF_FFFF, 32'h0);
      axi_write(16'h040, 32'hFFFF_FFFF, 4'hF);
      axi_write(16'h040, 32'h1234_5678, 4'b0101);
      rd_chk("bp0_wstrb", 16'h040, 32'hFFFF_FFFF, 32'hFF34_FF78);
      axi_write(16'h040, 32'h0, 4'hF);

      // Three-cycle step
      axi_write(16'h008, 32'd3, 4'hF);
      rd_chk("step_count_lowbits", 16'h00B, 32'hFFFF_FFFF, 32'd3);
      base = cexec_hi;
      axi_write(16'h000, 32'h4, 4'hF);
      tick(10);
      chk("step_cexec_cycles", 32'(cexec_hi - base), 32'd3);
      rd_chk("step_cycle", 16'h00C, 32'hFFFF_FFFF, 32'd3);
      rd_chk("step_status", 16'h004, 32'hFFFF_FFFF, 32'h0);

      // STOP beats RUN and STEP from HALT
      base = cexec_hi;
      axi_write(16'h000, 32'h7, 4'hF);
      tick(5);
      chk("ctrl7_cexec", {31'd0, cexec}, 32'd0);
      chk("ctrl7_no_exec", 32'(cexec_hi - base), 32'd0);
      rd_chk("ctrl7_status", 16'h004, 32'hFFFF_FFFF, 32'h0);

      // Breakpoint at 0x40 on index 1
      pc_set = 32'h0;
      tick(2);
      ramp = 1'b1;
      axi_write(16'h044, 32'h40, 4'hF);
      axi_write(16'h010, 32'h2, 4'hF);
      rd_chk("bp_en", 16'h010, 32'hFFFF_FFFF, 32'h2);
      base = cexec_hi;
      axi_write(16'h000, 32'h9, 4'hF);
      tick(30);
      chk("bp_pc", core_pc, 32'h40);
      chk("bp_cexec", {31'd0, cexec}, 32'd0);
      chk("bp_exec_cycles", 32'(cexec_hi - base), 32'd16);
      rd_chk("bp_status", 16'h004, 32'hFFFF_FFFF, 32'h104);
      rd_chk("bp_cycle", 16'h00C, 32'hFFFF_FFFF, 32'd16);

      // Resume past the breakpoint
      axi_write(16'h000, 32'h1, 4'hF);
      tick(5);
      chk("resume_cexec", {31'd0, cexec}, 32'd1);
      chk("resume_pc_moved", {31'd0, core_pc > 32'h40}, 32'd1);
      rd_chk("resume_status", 16'h004, 32'h7, 32'h1);
      axi_write(16'h000, 32'h2, 4'hF);
      tick(3);
      chk("stop_cexec", {31'd0, cexec}, 32'd0);
      rd_chk("stop_status", 16'h004, 32'h7, 32'h0);

      // RUN beats STEP
      ramp = 1'b0;
      pc_set = 32'h1000;
      tick(2);
      axi_write(16'h000, 32'h5, 4'hF);
      tick(3);
      rd_chk("run_over_step", 16'h004, 32'h3, 32'h1);
      axi_write(16'h000, 32'h2, 4'hF);
      tick(3);

      // Cycle counter wrap and clear-vs-increment
      #2;
      dut.cycle_cnt = 32'hFFFF_FFFF;
      tick(1);
      rd_chk("cycle_preload", 16'h00C, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      axi_write(16'h008, 32'd1, 4'hF);
      base = cexec_hi;
      axi_write(16'h000, 32'h4, 4'hF);
      tick(4);
      chk("wrap_one_cycle", 32'(cexec_hi - base), 32'd1);
      rd_chk("cycle_wrap", 16'h00C, 32'hFFFF_FFFF, 32'h0);
      axi_write(16'h000, 32'h1, 4'hF);
      tick(5);
      axi_write(16'h000, 32'hA, 4'hF);
      tick(2);
      rd_chk("cycle_clr_in_run", 16'h00C, 32'hFFFF_FFFF, 32'h0);
      rd_chk("clr_stop_status", 16'h004, 32'h3, 32'h0);

      // Reset while stepping with AW accepted and W pending
      axi_write(16'h008, 32'd100, 4'hF);
      axi_write(16'h000, 32'h4, 4'hF);
      tick(2);
      chk("pre_rst_cexec", {31'd0, cexec}, 32'd1);
      s_axi_awaddr = 16'h008; s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b0; s_axi_bready = 1'b1;
      n = 0;
      while (n < 20) begin
         @(negedge s_axi_aclk);
         if (s_axi_awready) break;
         n++;
      end
      chk("aw_only_accept", {31'd0, s_axi_awready}, 32'd1);
      @(posedge s_axi_aclk);
      #1;
      s_axi_awvalid = 1'b0;
      tick(1);
      #3;
      s_axi_aresetn = 1'b0;
      #1;
      chk("mid_rst_cexec", {31'd0, cexec}, 32'd0);
      chk("mid_rst_bvalid", {31'd0, s_axi_bvalid}, 32'd0);
      chk("mid_rst_readys", {29'd0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'd0);
      tick(2);
      #3;
      s_axi_aresetn = 1'b1;
      tick(4);
      chk("post_rst_no_bvalid", {31'd0, s_axi_bvalid}, 32'd0);
      s_axi_bready = 1'b0;
      rd_chk("post_rst_status", 16'h004, 32'hFFFF_FFFF, 32'h0);
      rd_chk("post_rst_step_count", 16'h008, 32'hFFFF_FFFF, 32'h0);
      rd_chk("post_rst_cycle", 16'h00C, 32'hFFFF_FFFF, 32'h0);
      rd_chk("post_rst_bp_en", 16'h010, 32'hFFFF_FFFF, 32'h0);
      rd_chk("post_rst_bp1", 16'h044, 32'hFFFF_FFFF, 32'h0);
      chk("post_rst_cexec", {31'd0, cexec}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
